// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht
//   Branch unit for the pipelined MIPS core. It resolves conditional branches
//   in D (beq/bne/bgez/bgtz/blez/bltz) and trains a direct-mapped table of
//   saturating counters (no tags) that F reads for its taken/not-taken
//   prediction. It also keeps two perf counters: resolved branches and
//   mispredicts.
//
// Ports
//   clk, reset       rising-edge clock; synchronous active-high reset
//   f_pc             fetch PC looked up in the table
//   f_pred_taken     MSB of the indexed counter (combinational, pre-update)
//   d_valid/d_stall  D-stage valid; a stall blocks every state update
//   d_pc             PC of the D-stage instruction (selects the trained entry)
//   A, B             forwarded rs/rt operands
//   CompOp           1 beq, 2 bne, 3 bgez, 4 bgtz, 5 blez, 6 bltz, else none
//   d_pred_taken     prediction that F made for this instruction
//   taken            actual branch outcome (combinational)
//   mispredict       valid branch whose outcome differs from the prediction
//   br_cnt/mis_cnt   wrapping perf counters
//
// Per-entry counter states (CTR_BITS=2)
//   state    | meaning
//   SNT (00) | strongly not-taken
//   WNT (01) | weakly not-taken, reset value
//   WT  (10) | weakly taken
//   ST  (11) | strongly taken
//   A taken branch moves one state toward ST and a not-taken branch moves one
//   state toward SNT. Both ends saturate.

module branch_resolve_bht #(
  parameter int WIDTH    = 32,
  parameter int IDX_BITS = 6,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  f_pc,
  output logic              f_pred_taken,
  input  logic              d_valid,
  input  logic              d_stall,
  input  logic [WIDTH-1:0]  d_pc,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [3:0]        CompOp,
  input  logic              d_pred_taken,
  output logic              taken,
  output logic              mispredict,
  output logic [STAT_W-1:0] br_cnt,
  output logic [STAT_W-1:0] mis_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;

  localparam logic [3:0] OP_BEQ  = 4'd1;
  localparam logic [3:0] OP_BNE  = 4'd2;
  localparam logic [3:0] OP_BGEZ = 4'd3;
  localparam logic [3:0] OP_BGTZ = 4'd4;
  localparam logic [3:0] OP_BLEZ = 4'd5;
  localparam logic [3:0] OP_BLTZ = 4'd6;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  // The weakly not-taken value is 2**(CTR_BITS-1)-1, which is all ones shifted right by one.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

  logic [CTR_BITS-1:0] bht [ENTRIES];

  logic [IDX_BITS-1:0] f_idx;
  logic [IDX_BITS-1:0] d_idx;
  logic                is_branch;
  logic                a_neg;
  logic                a_zero;
  logic                upd;
  logic [CTR_BITS-1:0] cur_ctr;
  logic [CTR_BITS-1:0] nxt_ctr;

  // The PC bits outside the index field do not take part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[WIDTH-1:IDX_BITS+2], f_pc[1:0],
                            d_pc[WIDTH-1:IDX_BITS+2], d_pc[1:0]};

  assign f_idx = f_pc[IDX_BITS+1:2];
  assign d_idx = d_pc[IDX_BITS+1:2];

  // A read from the table array returns the value from before any same-cycle write.
  assign f_pred_taken = bht[f_idx][CTR_BITS-1];

  // The sign tests against zero look only at the MSB and at the all-zero case.
  // B does not take part in them.
  assign a_neg  = A[WIDTH-1];
  assign a_zero = (A == '0);

  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    case (CompOp)
      OP_BEQ:  begin is_branch = 1'b1; taken = (A == B);           end
      OP_BNE:  begin is_branch = 1'b1; taken = (A != B);           end
      OP_BGEZ: begin is_branch = 1'b1; taken = ~a_neg;             end
      OP_BGTZ: begin is_branch = 1'b1; taken = ~a_neg & ~a_zero;   end
      OP_BLEZ: begin is_branch = 1'b1; taken = a_neg | a_zero;     end
      OP_BLTZ: begin is_branch = 1'b1; taken = a_neg;              end
      default: begin is_branch = 1'b0; taken = 1'b0;               end
    endcase
  end

  assign mispredict = d_valid & is_branch & (taken != d_pred_taken);
  assign upd        = d_valid & is_branch & ~d_stall;

  assign cur_ctr = bht[d_idx];

  always_comb begin
    nxt_ctr = cur_ctr;
    if (taken) begin
      if (cur_ctr != CTR_MAX) nxt_ctr = cur_ctr + CTR_BITS'(1);
    end else begin
      if (cur_ctr != '0) nxt_ctr = cur_ctr - CTR_BITS'(1);
    end
  end

  // Reset has priority, so an update that is in flight when reset arrives is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= CTR_INIT;
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else if (upd) begin
      bht[d_idx] <= nxt_ctr;
      br_cnt     <= br_cnt + STAT_W'(1);
      if (mispredict) mis_cnt <= mis_cnt + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
module tb_branch_resolve_bht;

  localparam int SW = 8;  // small perf counters so the wrap is reachable quickly

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   f_pc;
  logic          f_pred_taken;
  logic          d_valid, d_stall;
  logic [31:0]   d_pc, A, B;
  logic [3:0]    CompOp;
  logic          d_pred_taken;
  logic          taken, mispredict;
  logic [SW-1:0] br_cnt, mis_cnt;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  // Behavioural model: one integer per table entry, plus plain integer counters.
  int m_tab [64];
  int m_br, m_mis;

  always #5 clk = ~clk;

  branch_resolve_bht #(.WIDTH(32), .IDX_BITS(6), .CTR_BITS(2), .STAT_W(SW)) dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .d_valid(d_valid), .d_stall(d_stall), .d_pc(d_pc), .A(A), .B(B),
    .CompOp(CompOp), .d_pred_taken(d_pred_taken), .taken(taken),
    .mispredict(mispredict), .br_cnt(br_cnt), .mis_cnt(mis_cnt));

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic bit m_isbr(logic [3:0] op);
    return (op >= 1) && (op <= 6);
  endfunction

  function automatic bit m_taken(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      4'd1: return a == b;
      4'd2: return a != b;
      4'd3: return sa >= 0;
      4'd4: return sa > 0;
      4'd5: return sa <= 0;
      4'd6: return sa < 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) m_tab[i] = 1;
      m_br = 0;
      m_mis = 0;
    end else if (d_valid && m_isbr(CompOp) && !d_stall) begin
      automatic bit t = m_taken(CompOp, A, B);
      automatic int k = m_idx(d_pc);
      if (t) m_tab[k] = (m_tab[k] < 3) ? m_tab[k] + 1 : 3;
      else   m_tab[k] = (m_tab[k] > 0) ? m_tab[k] - 1 : 0;
      m_br = (m_br + 1) % (1 << SW);
      if (t != d_pred_taken) m_mis = (m_mis + 1) % (1 << SW);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit t = m_taken(CompOp, A, B);
      chk("cyc_taken", taken, t);
      chk("cyc_mispredict", mispredict, d_valid && m_isbr(CompOp) && (t != d_pred_taken));
      chk("cyc_f_pred", f_pred_taken, m_tab[m_idx(f_pc)] >= 2);
      chk("cyc_br_cnt", br_cnt, m_br);
      chk("cyc_mis_cnt", mis_cnt, m_mis);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input bit v, input bit st, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input bit pred);
    d_valid = v; d_stall = st; d_pc = pc; A = a; B = b; CompOp = op; d_pred_taken = pred;
    #1;
  endtask

  task automatic idle();
    set_br(0, 0, 32'h0, 32'h0, 32'h0, 4'd0, 0);
  endtask

  typedef struct {logic [3:0] op; logic [31:0] a; logic [31:0] b; bit exp; string nm;} vec_t;

  initial begin
    vec_t vecs [8];
    vecs[0] = '{4'd6, 32'h8000_0000, 32'h0, 1'b1, "bltz_min"};
    vecs[1] = '{4'd4, 32'h0,         32'h5, 1'b0, "bgtz_zero"};
    vecs[2] = '{4'd5, 32'h0,         32'h0, 1'b1, "blez_zero"};
    vecs[3] = '{4'd3, 32'hffff_ffff, 32'h0, 1'b0, "bgez_m1"};
    vecs[4] = '{4'd2, 32'h7,         32'h7, 1'b0, "bne_eq"};
    vecs[5] = '{4'd4, 32'h1,         32'h0, 1'b1, "bgtz_one"};
    vecs[6] = '{4'd6, 32'h7fff_ffff, 32'h0, 1'b0, "bltz_max"};
    vecs[7] = '{4'd3, 32'h0,         32'h9, 1'b1, "bgez_zero"};

    reset = 1; f_pc = 32'h3000;
    idle();
    tick(); tick();
    reset = 0;
    chk_en = 1;

    // 1: table comes out of reset weakly not-taken, counters cleared
    f_pc = 32'h3000; #1 chk("rst_pred_3000", f_pred_taken, 0);
    f_pc = 32'h3ffc; #1 chk("rst_pred_3ffc", f_pred_taken, 0);
    chk("rst_br", br_cnt, 0);
    chk("rst_mis", mis_cnt, 0);

    // 2: first taken beq trains 01 -> 10
    f_pc = 32'h3000;
    set_br(1, 0, 32'h3000, 5, 5, 4'd1, 0);
    chk("beq_taken", taken, 1);
    chk("beq_mispredict", mispredict, 1);
    tick(); idle();
    chk("beq_trained_pred", f_pred_taken, 1);
    chk("beq_br", br_cnt, 1);
    chk("beq_mis", mis_cnt, 1);

    // 3: saturate high, then walk down and saturate low
    for (int i = 0; i < 4; i++) begin set_br(1, 0, 32'h3000, 5, 5, 4'd1, 1); tick(); end
    idle();
    chk("sat_hi_pred", f_pred_taken, 1);
    chk("sat_hi_br", br_cnt, 5);
    set_br(1, 0, 32'h3000, 5, 6, 4'd1, 1); tick(); idle();
    chk("st_to_wt_pred", f_pred_taken, 1);
    for (int i = 0; i < 2; i++) begin set_br(1, 0, 32'h3000, 5, 6, 4'd1, 1); tick(); end
    idle();
    chk("down_to_snt_pred", f_pred_taken, 0);
    chk("down_mis", mis_cnt, 4);
    set_br(1, 0, 32'h3000, 5, 6, 4'd1, 0); tick(); idle();
    chk("sat_lo_pred", f_pred_taken, 0);
    set_br(1, 0, 32'h3000, 1, 1, 4'd1, 0); tick(); idle();
    chk("snt_up1_pred", f_pred_taken, 0);
    set_br(1, 0, 32'h3000, 1, 1, 4'd1, 0); tick(); idle();
    chk("snt_up2_pred", f_pred_taken, 1);
    chk("sec3_br", br_cnt, 11);
    chk("sec3_mis", mis_cnt, 6);

    // 4: signed compares and a non-branch opcode
    foreach (vecs[i]) begin
      set_br(1, 0, 32'h3004, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
      chk(vecs[i].nm, taken, vecs[i].exp);
      tick();
    end
    set_br(1, 0, 32'h3004, 32'h0, 32'h0, 4'd9, 1);
    chk("op9_taken", taken, 0);
    chk("op9_mispredict", mispredict, 0);
    tick(); idle();
    chk("op9_br", br_cnt, 19);

    // 5: stall shows the outcome but trains nothing; aliasing PC hits entry 0
    set_br(1, 1, 32'h3000, 1, 1, 4'd1, 0);
    chk("stall_taken", taken, 1);
    tick();
    set_br(1, 1, 32'h3000, 1, 2, 4'd1, 1);
    tick(); idle();
    chk("stall_pred_kept", f_pred_taken, 1);
    chk("stall_br", br_cnt, 19);
    set_br(1, 0, 32'h3100, 1, 2, 4'd1, 1); tick(); idle();
    chk("alias_pred", f_pred_taken, 0);
    set_br(1, 0, 32'h3100, 1, 2, 4'd1, 1); tick(); idle();
    // entry 0 is now 00

    // 6: same-cycle lookup sees the pre-update value
    set_br(1, 0, 32'h3000, 3, 3, 4'd1, 0); tick();
    set_br(1, 0, 32'h3000, 3, 3, 4'd1, 0);
    chk("same_cyc_old", f_pred_taken, 0);
    tick(); idle();
    chk("same_cyc_new", f_pred_taken, 1);

    // reset wins over a simultaneous update
    reset = 1;
    set_br(1, 0, 32'h3000, 3, 3, 4'd1, 0);
    tick();
    reset = 0; idle();
    chk("rst_upd_pred", f_pred_taken, 0);
    chk("rst_upd_br", br_cnt, 0);
    chk("rst_upd_mis", mis_cnt, 0);
    for (int i = 0; i < 64; i++) begin
      f_pc = 32'h5000 + 32'(i * 4); #1;
      if (f_pred_taken !== 1'b0) chk("rst_all_entries", f_pred_taken, 0);
    end
    f_pc = 32'h3000;

    // perf counter wrap with mixed traffic
    for (int i = 0; i < 255; i++) begin
      set_br(1, 0, 32'(i * 4), $urandom, $urandom_range(3), 4'($urandom_range(1, 6)),
             1'($urandom_range(1)));
      tick();
    end
    idle();
    chk("wrap_br_255", br_cnt, 255);
    set_br(1, 0, 32'h3000, 0, 0, 4'd1, 1); tick(); idle();
    chk("wrap_br_0", br_cnt, 0);

    tick();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
